// File: rtl/dm_window_sequencer_if.sv
// Address/framing beat bus between the window sequencer and the SAD datapath.
interface dm_window_sequencer_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              addr_valid;
    logic              addr_ready;
    logic [ADDR_W-1:0] addr_l;
    logic [ADDR_W-1:0] addr_r;
    logic              oob;
    logic [5:0]        disp;
    logic [11:0]       pix_row;
    logic [11:0]       pix_col;
    logic              win_first;
    logic              win_last;
    logic              pix_last;
    logic              frame_last;

    modport master (
        output addr_valid, addr_l, addr_r, oob, disp, pix_row, pix_col,
        output win_first, win_last, pix_last, frame_last,
        input  addr_ready
    );

    modport slave (
        input  addr_valid, addr_l, addr_r, oob, disp, pix_row, pix_col,
        input  win_first, win_last, pix_last, frame_last,
        output addr_ready
    );
endinterface

// File: rtl/dm_window_sequencer.sv
// Walks centre pixels, disparities and window taps of a frame, emitting one
// left/right BRAM address pair per handshake together with SAD framing flags.
module dm_window_sequencer #(
    parameter int unsigned IMG_COLS   = 640,
    parameter int unsigned IMG_ROWS   = 480,
    parameter int unsigned NUM_OF_WIN = 64,
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned RIGHT_BASE = 307200
) (
    input  logic                  clka,
    input  logic                  reset,
    input  logic                  go,
    input  logic [2:0]            window,
    input  logic                  abort,
    dm_window_sequencer_if.master bus,
    output logic                  busy,
    output logic                  done,
    output logic                  cfg_err
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StLoad = 2'd1;
    localparam logic [1:0] StRun  = 2'd2;
    localparam logic [1:0] StDone = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [1:0]        h_q, h_d;
    logic [11:0]       row_q, row_d;
    logic [11:0]       col_q, col_d;
    logic [5:0]        d_q, d_d;
    logic signed [3:0] i_q, i_d;
    logic signed [3:0] j_q, j_d;
    // row_top tracks (row-H)*IMG_COLS, row_base tracks (row+i)*IMG_COLS
    logic [ADDR_W-1:0] row_top_q, row_top_d;
    logic [ADDR_W-1:0] row_base_q, row_base_d;
    logic              valid_q, valid_d;
    logic              cfg_err_q, cfg_err_d;

    logic signed [3:0]  h_s, neg_h;
    logic               j_last, i_last, d_last, col_last, row_last;
    logic               win_first_c, win_last_c, pix_last_c, frame_last_c;
    logic               hs;
    logic signed [13:0] col_j, col_jd;
    logic               oob_c;
    logic [ADDR_W-1:0]  addr_l_c, addr_r_c;

    assign h_s   = $signed({2'b00, h_q});
    assign neg_h = -h_s;

    assign j_last   = (j_q == h_s);
    assign i_last   = (i_q == h_s);
    assign d_last   = (d_q == 6'(NUM_OF_WIN - 1));
    assign col_last = (col_q == 12'(IMG_COLS - 1) - {10'b0, h_q});
    assign row_last = (row_q == 12'(IMG_ROWS - 1) - {10'b0, h_q});

    assign win_first_c  = (i_q == neg_h) && (j_q == neg_h);
    assign win_last_c   = i_last && j_last;
    assign pix_last_c   = win_last_c && d_last;
    assign frame_last_c = pix_last_c && row_last && col_last;

    assign hs = valid_q && bus.addr_ready;

    // Negative right-image column is clamped to the row start and flagged
    assign col_j    = $signed({2'b00, col_q}) + $signed({{10{j_q[3]}}, j_q});
    assign col_jd   = col_j - $signed({8'b0, d_q});
    assign oob_c    = col_jd[13];
    assign addr_l_c = row_base_q + ADDR_W'($unsigned(col_j));
    assign addr_r_c = ADDR_W'(RIGHT_BASE) + row_base_q
                    + (oob_c ? '0 : ADDR_W'($unsigned(col_jd)));

    always_comb begin
        state_d    = state_q;
        h_d        = h_q;
        row_d      = row_q;
        col_d      = col_q;
        d_d        = d_q;
        i_d        = i_q;
        j_d        = j_q;
        row_top_d  = row_top_q;
        row_base_d = row_base_q;
        valid_d    = valid_q;
        cfg_err_d  = 1'b0;

        case (state_q)
            StIdle: begin
                if (go) begin
                    if (window == 3'b011 || window == 3'b101 || window == 3'b111) begin
                        h_d     = window[2:1];
                        state_d = StLoad;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            StLoad: begin
                row_d      = {10'b0, h_q};
                col_d      = {10'b0, h_q};
                d_d        = '0;
                i_d        = neg_h;
                j_d        = neg_h;
                row_top_d  = '0;
                row_base_d = '0;
                valid_d    = 1'b1;
                state_d    = StRun;
            end
            StRun: begin
                if (hs) begin
                    if (frame_last_c) begin
                        valid_d = 1'b0;
                        state_d = StDone;
                    end else if (!j_last) begin
                        j_d = j_q + 4'sd1;
                    end else begin
                        j_d = neg_h;
                        if (!i_last) begin
                            i_d        = i_q + 4'sd1;
                            row_base_d = row_base_q + ADDR_W'(IMG_COLS);
                        end else begin
                            i_d        = neg_h;
                            row_base_d = row_top_q;
                            if (!d_last) begin
                                d_d = d_q + 6'd1;
                            end else begin
                                d_d = '0;
                                if (!col_last) begin
                                    col_d = col_q + 12'd1;
                                end else begin
                                    col_d      = {10'b0, h_q};
                                    row_d      = row_q + 12'd1;
                                    row_top_d  = row_top_q + ADDR_W'(IMG_COLS);
                                    row_base_d = row_top_q + ADDR_W'(IMG_COLS);
                                end
                            end
                        end
                    end
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        // Abort wins over any handshake in the same cycle
        if (abort && state_q != StIdle) begin
            state_d = StIdle;
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clka or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            h_q        <= '0;
            row_q      <= '0;
            col_q      <= '0;
            d_q        <= '0;
            i_q        <= '0;
            j_q        <= '0;
            row_top_q  <= '0;
            row_base_q <= '0;
            valid_q    <= 1'b0;
            cfg_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            h_q        <= h_d;
            row_q      <= row_d;
            col_q      <= col_d;
            d_q        <= d_d;
            i_q        <= i_d;
            j_q        <= j_d;
            row_top_q  <= row_top_d;
            row_base_q <= row_base_d;
            valid_q    <= valid_d;
            cfg_err_q  <= cfg_err_d;
        end
    end

    assign bus.addr_valid = valid_q;
    assign bus.addr_l     = valid_q ? addr_l_c : '0;
    assign bus.addr_r     = valid_q ? addr_r_c : '0;
    assign bus.oob        = valid_q && oob_c;
    assign bus.disp       = valid_q ? d_q : '0;
    assign bus.pix_row    = valid_q ? row_q : '0;
    assign bus.pix_col    = valid_q ? col_q : '0;
    assign bus.win_first  = valid_q && win_first_c;
    assign bus.win_last   = valid_q && win_last_c;
    assign bus.pix_last   = valid_q && pix_last_c;
    assign bus.frame_last = valid_q && frame_last_c;

    assign busy    = (state_q == StLoad) || (state_q == StRun);
    assign done    = (state_q == StDone);
    assign cfg_err = cfg_err_q;

endmodule

// File: tb/tb_dm_window_sequencer.sv
// Directed bench for dm_window_sequencer: an 8x6 instance for the 3x3 scenarios
// and a 10x8 instance for the 7x7 stalled run, checked against a loop-index model.
module tb_dm_window_sequencer;

    localparam int AW = 32;

    logic clka  = 1'b0;
    logic reset = 1'b0;
    always #5 clka = ~clka;

    int n_checks = 0;
    int n_fail   = 0;

    logic       go_a = 1'b0, abort_a = 1'b0;
    logic [2:0] win_a = 3'b000;
    logic       busy_a, done_a, cfg_err_a;
    logic       go_b = 1'b0, abort_b = 1'b0;
    logic [2:0] win_b = 3'b000;
    logic       busy_b, done_b, cfg_err_b;

    dm_window_sequencer_if #(.ADDR_W(AW)) bus_a ();
    dm_window_sequencer_if #(.ADDR_W(AW)) bus_b ();

    dm_window_sequencer #(
        .IMG_COLS(8), .IMG_ROWS(6), .NUM_OF_WIN(2), .ADDR_W(AW), .RIGHT_BASE(64)
    ) u_dut_a (
        .clka(clka), .reset(reset), .go(go_a), .window(win_a), .abort(abort_a),
        .bus(bus_a), .busy(busy_a), .done(done_a), .cfg_err(cfg_err_a)
    );

    dm_window_sequencer #(
        .IMG_COLS(10), .IMG_ROWS(8), .NUM_OF_WIN(2), .ADDR_W(AW), .RIGHT_BASE(64)
    ) u_dut_b (
        .clka(clka), .reset(reset), .go(go_b), .window(win_b), .abort(abort_b),
        .bus(bus_b), .busy(busy_b), .done(done_b), .cfg_err(cfg_err_b)
    );

    function automatic logic [98:0] pack_a();
        return {bus_a.addr_l, bus_a.addr_r, bus_a.oob, bus_a.disp, bus_a.pix_row,
                bus_a.pix_col, bus_a.win_first, bus_a.win_last, bus_a.pix_last,
                bus_a.frame_last};
    endfunction

    function automatic logic [98:0] pack_b();
        return {bus_b.addr_l, bus_b.addr_r, bus_b.oob, bus_b.disp, bus_b.pix_row,
                bus_b.pix_col, bus_b.win_first, bus_b.win_last, bus_b.pix_last,
                bus_b.frame_last};
    endfunction

    // Expected beat n, decoded directly from the loop nest (j innermost)
    function automatic logic [98:0] model_pack(input int n, input int h, input int cols,
                                               input int rows, input int nw, input int rb);
        int w, k, j, i, d, row, col, c, el, er;
        logic oob, wf, wl, pl, fl;
        w   = 2 * h + 1;
        k   = n;
        j   = k % w - h;  k = k / w;
        i   = k % w - h;  k = k / w;
        d   = k % nw;     k = k / nw;
        col = h + k % (cols - 2 * h);
        row = h + k / (cols - 2 * h);
        c   = col + j - d;
        oob = (c < 0);
        el  = (row + i) * cols + col + j;
        er  = rb + (row + i) * cols + (oob ? 0 : c);
        wf  = (i == -h) && (j == -h);
        wl  = (i == h) && (j == h);
        pl  = wl && (d == nw - 1);
        fl  = pl && (row == rows - 1 - h) && (col == cols - 1 - h);
        return {32'(el), 32'(er), oob, 6'(d), 12'(row), 12'(col), wf, wl, pl, fl};
    endfunction

    task automatic test_reset();
        #2;
        n_checks++;
        if (pack_a() !== '0 || bus_a.addr_valid !== 1'b0 || busy_a !== 1'b0 ||
            done_a !== 1'b0 || cfg_err_a !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_a: bus=%h valid=%b busy=%b done=%b cfg_err=%b, want all 0",
                     pack_a(), bus_a.addr_valid, busy_a, done_a, cfg_err_a);
        end
        n_checks++;
        if (pack_b() !== '0 || bus_b.addr_valid !== 1'b0 || busy_b !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_b: bus=%h valid=%b busy=%b, want all 0",
                     pack_b(), bus_b.addr_valid, busy_b);
        end
        @(negedge clka);
        reset = 1'b1;
        @(negedge clka);
        n_checks++;
        if (bus_a.addr_valid !== 1'b0 || busy_a !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_release: valid=%b busy=%b, want 0 0",
                     bus_a.addr_valid, busy_a);
        end
    endtask

    task automatic test_full_frame();
        int beats;
        logic fin;
        logic [98:0] exp_v, act_v;
        beats = 0;
        fin   = 1'b0;
        @(negedge clka);
        win_a = 3'b011; go_a = 1'b1; bus_a.addr_ready = 1'b1;
        @(negedge clka);
        go_a = 1'b0; win_a = 3'b000;
        n_checks++;
        if (bus_a.addr_valid !== 1'b0 || busy_a !== 1'b1) begin
            n_fail++;
            $display("FAIL load_state: valid=%b busy=%b, want valid=0 busy=1",
                     bus_a.addr_valid, busy_a);
        end
        @(negedge clka);
        act_v = pack_a();
        exp_v = {32'd0, 32'd64, 1'b0, 6'd0, 12'd1, 12'd1, 4'b1000};
        n_checks++;
        if (bus_a.addr_valid !== 1'b1 || act_v !== exp_v) begin
            n_fail++;
            $display("FAIL first_beat: valid=%b bus=%h, want valid=1 bus=%h",
                     bus_a.addr_valid, act_v, exp_v);
        end
        for (int cyc = 0; cyc < 2000 && !fin; cyc++) begin
            // A go with a different window mid-frame must be ignored
            go_a  = (beats == 100);
            win_a = (beats == 100) ? 3'b111 : 3'b000;
            if (bus_a.addr_valid && bus_a.addr_ready) begin
                act_v = pack_a();
                exp_v = model_pack(beats, 1, 8, 6, 2, 64);
                n_checks++;
                if (act_v !== exp_v) begin
                    n_fail++;
                    $display("FAIL frame_beat %0d: got %h, want %h", beats, act_v, exp_v);
                end
                if (beats == 9) begin
                    n_checks++;
                    if (bus_a.oob !== 1'b1 || bus_a.addr_r !== 32'd64 || bus_a.addr_l !== 32'd0 ||
                        bus_a.win_first !== 1'b1 || bus_a.disp !== 6'd1) begin
                        n_fail++;
                        $display("FAIL beat10_oob: oob=%b addr_r=%0d addr_l=%0d wf=%b disp=%0d, want 1 64 0 1 1",
                                 bus_a.oob, bus_a.addr_r, bus_a.addr_l, bus_a.win_first, bus_a.disp);
                    end
                end
                fin = exp_v[0];
                beats++;
            end
            @(negedge clka);
        end
        go_a = 1'b0;
        n_checks++;
        if (!fin) begin
            n_fail++;
            $display("FAIL frame_timeout: frame_last not reached, got %0d beats, want 432", beats);
        end
        n_checks++;
        if (beats != 432) begin
            n_fail++;
            $display("FAIL beat_count: got %0d, want 432", beats);
        end
        n_checks++;
        if (bus_a.addr_valid !== 1'b0 || done_a !== 1'b1 || busy_a !== 1'b0) begin
            n_fail++;
            $display("FAIL done_pulse: valid=%b done=%b busy=%b, want 0 1 0",
                     bus_a.addr_valid, done_a, busy_a);
        end
        @(negedge clka);
        n_checks++;
        if (done_a !== 1'b0 || busy_a !== 1'b0 || bus_a.addr_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL done_one_cycle: done=%b busy=%b valid=%b, want 0 0 0",
                     done_a, busy_a, bus_a.addr_valid);
        end
    endtask

    task automatic test_cfg_err();
        @(negedge clka);
        win_a = 3'b100; go_a = 1'b1;
        @(negedge clka);
        go_a = 1'b0;
        n_checks++;
        if (cfg_err_a !== 1'b1 || busy_a !== 1'b0 || bus_a.addr_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL cfg_err_pulse: cfg_err=%b busy=%b valid=%b, want 1 0 0",
                     cfg_err_a, busy_a, bus_a.addr_valid);
        end
        @(negedge clka);
        n_checks++;
        if (cfg_err_a !== 1'b0 || busy_a !== 1'b0 || bus_a.addr_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL cfg_err_one_cycle: cfg_err=%b busy=%b valid=%b, want 0 0 0",
                     cfg_err_a, busy_a, bus_a.addr_valid);
        end
    endtask

    task automatic test_abort();
        int beats;
        logic hit;
        logic [98:0] exp_v;
        beats = 0;
        hit   = 1'b0;
        @(negedge clka);
        win_a = 3'b011; go_a = 1'b1; bus_a.addr_ready = 1'b1;
        @(negedge clka);
        go_a = 1'b0;
        for (int cyc = 0; cyc < 200 && !hit; cyc++) begin
            if (bus_a.addr_valid && bus_a.addr_ready) begin
                if (beats == 49) begin
                    abort_a = 1'b1;
                    hit     = 1'b1;
                end
                beats++;
            end
            @(negedge clka);
        end
        abort_a = 1'b0;
        n_checks++;
        if (!hit || bus_a.addr_valid !== 1'b0 || busy_a !== 1'b0 || done_a !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_idle: hit=%b valid=%b busy=%b done=%b, want 1 0 0 0",
                     hit, bus_a.addr_valid, busy_a, done_a);
        end
        @(negedge clka);
        n_checks++;
        if (done_a !== 1'b0 || bus_a.addr_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_no_done: done=%b valid=%b, want 0 0", done_a, bus_a.addr_valid);
        end
        win_a = 3'b011; go_a = 1'b1;
        @(negedge clka);
        go_a = 1'b0;
        @(negedge clka);
        exp_v = model_pack(0, 1, 8, 6, 2, 64);
        n_checks++;
        if (bus_a.addr_valid !== 1'b1 || pack_a() !== exp_v) begin
            n_fail++;
            $display("FAIL restart_after_abort: valid=%b bus=%h, want 1 %h",
                     bus_a.addr_valid, pack_a(), exp_v);
        end
        abort_a = 1'b1;
        @(negedge clka);
        abort_a = 1'b0;
    endtask

    task automatic test_async_reset();
        int beats;
        logic hit;
        logic [98:0] exp_v;
        beats = 0;
        hit   = 1'b0;
        @(negedge clka);
        win_a = 3'b011; go_a = 1'b1; bus_a.addr_ready = 1'b1;
        @(negedge clka);
        go_a = 1'b0;
        for (int cyc = 0; cyc < 200 && !hit; cyc++) begin
            if (bus_a.addr_valid && bus_a.addr_ready) beats++;
            if (beats == 20) hit = 1'b1;
            else @(negedge clka);
        end
        #1 reset = 1'b0;
        #1;
        n_checks++;
        if (!hit || pack_a() !== '0 || bus_a.addr_valid !== 1'b0 || busy_a !== 1'b0 ||
            done_a !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset_outputs: hit=%b bus=%h valid=%b busy=%b done=%b, want 1 0 0 0 0",
                     hit, pack_a(), bus_a.addr_valid, busy_a, done_a);
        end
        @(negedge clka);
        reset = 1'b1;
        @(negedge clka);
        n_checks++;
        if (bus_a.addr_valid !== 1'b0 || busy_a !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: valid=%b busy=%b, want 0 0", bus_a.addr_valid, busy_a);
        end
        win_a = 3'b011; go_a = 1'b1;
        @(negedge clka);
        go_a = 1'b0;
        @(negedge clka);
        exp_v = model_pack(0, 1, 8, 6, 2, 64);
        n_checks++;
        if (bus_a.addr_valid !== 1'b1 || pack_a() !== exp_v) begin
            n_fail++;
            $display("FAIL restart_after_reset: valid=%b bus=%h, want 1 %h",
                     bus_a.addr_valid, pack_a(), exp_v);
        end
        abort_a = 1'b1;
        @(negedge clka);
        abort_a = 1'b0;
    endtask

    task automatic test_stall();
        int beats;
        logic fin, stalled;
        logic [98:0] exp_v, act_v, held;
        beats   = 0;
        fin     = 1'b0;
        stalled = 1'b0;
        held    = '0;
        @(negedge clka);
        win_b = 3'b111; go_b = 1'b1;
        @(negedge clka);
        go_b = 1'b0;
        for (int cyc = 0; cyc < 6000 && !fin; cyc++) begin
            bus_b.addr_ready = ($urandom_range(0, 9) >= 3);
            act_v = pack_b();
            if (stalled) begin
                n_checks++;
                if (bus_b.addr_valid !== 1'b1 || act_v !== held) begin
                    n_fail++;
                    $display("FAIL stall_hold beat %0d: valid=%b bus=%h, want 1 %h",
                             beats, bus_b.addr_valid, act_v, held);
                end
            end
            stalled = bus_b.addr_valid && !bus_b.addr_ready;
            held    = act_v;
            if (bus_b.addr_valid && bus_b.addr_ready) begin
                exp_v = model_pack(beats, 3, 10, 8, 2, 64);
                n_checks++;
                if (act_v !== exp_v) begin
                    n_fail++;
                    $display("FAIL stall_beat %0d: got %h, want %h", beats, act_v, exp_v);
                end
                fin = exp_v[0];
                beats++;
            end
            @(negedge clka);
        end
        n_checks++;
        if (beats != 784) begin
            n_fail++;
            $display("FAIL stall_beat_count: got %0d, want 784", beats);
        end
        n_checks++;
        if (bus_b.addr_valid !== 1'b0 || done_b !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_done: valid=%b done=%b, want 0 1", bus_b.addr_valid, done_b);
        end
    endtask

    initial begin
        bus_a.addr_ready = 1'b0;
        bus_b.addr_ready = 1'b0;
        test_reset();
        test_full_frame();
        test_cfg_err();
        test_abort();
        test_async_reset();
        test_stall();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
